// File: rtl/fifo_pkg.sv
// Shared defaults, FSM state encoding and the lane-keep helper for the
// FIFO read-side packer.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int PACK_RATIO_DEF = 4;
    localparam int MAX_LANES      = 32;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } state_t;

    // Low n bits set; callers truncate to their own lane count.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned n);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            mask[i] = (i < n);
        end
        return mask;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// One-entry valid/ready output register: loads a beat, holds it stable
// under backpressure and releases it on handshake.
module pack_out_reg #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_ready,
    output logic              o_free,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;

    // A load is only ever requested while o_free is high, so it may
    // coincide with the handshake of the previous beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: issues underflow-safe read strobes, packs
// PACK_RATIO words per beat and supports flushing a partial beat.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int PACK_RATIO = PACK_RATIO_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
    output logic                             fifo_rd_en,
    output logic [FIFO_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             flush,
    output logic                             flush_done,
    output logic                             busy
);

    localparam int                LANE_W = $clog2(PACK_RATIO);
    localparam int                FILL_W = LANE_W + 1;
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PACK_RATIO);

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [FILL_W-1:0]                    r_fill;
    logic                                 r_rd_pending;
    logic [PACK_RATIO-1:0][FIFO_WIDTH-1:0] r_acc;
    logic                                 r_flush_done;

    logic                                 w_rd_en;
    logic                                 w_slot_free;
    logic                                 w_load_full;
    logic                                 w_load_part;
    logic                                 w_load;
    logic                                 w_flush_done_nxt;
    logic [FILL_W:0]                      w_inflight;
    logic [PACK_RATIO-1:0]                w_load_keep;
    logic                                 w_out_valid;

    // Words already captured plus the one still arriving from the FIFO.
    assign w_inflight  = {1'b0, r_fill} + {{FILL_W{1'b0}}, r_rd_pending};
    assign w_load_full = (r_fill == FULL) && w_slot_free;
    assign w_load      = w_load_full || w_load_part;
    assign w_load_keep = PACK_RATIO'(keep_mask(32'(r_fill)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (flush) begin
                    w_state_nxt = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (!r_rd_pending && (r_fill != FULL)) begin
                    w_state_nxt = FLUSH_EMIT;
                end
            end
            FLUSH_EMIT: begin
                if ((r_fill == '0) || w_slot_free) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        w_rd_en          = 1'b0;
        w_load_part      = 1'b0;
        w_flush_done_nxt = 1'b0;
        if (!rst && (r_state == RUN) && !fifo_empty && (w_inflight < {1'b0, FULL})) begin
            w_rd_en = 1'b1;
        end
        if (r_state == FLUSH_EMIT) begin
            if (r_fill == '0) begin
                w_flush_done_nxt = 1'b1;
            end else if (w_slot_free) begin
                w_load_part      = 1'b1;
                w_flush_done_nxt = 1'b1;
            end
        end
    end

    // Accumulator is cleared on every load so lanes past fill read as zero
    // in a partial beat. A load needs fill==FULL or the flush path, both of
    // which imply no word is pending, so load and capture never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill       <= '0;
            r_rd_pending <= 1'b0;
            r_acc        <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_en;
            r_flush_done <= w_flush_done_nxt;
            if (w_load) begin
                r_fill <= '0;
                r_acc  <= '0;
            end else if (r_rd_pending) begin
                r_acc[r_fill[LANE_W-1:0]] <= fifo_data_out;
                r_fill                    <= r_fill + FILL_W'(1);
            end
        end
    end

    pack_out_reg #(
        .DATA_W (FIFO_WIDTH*PACK_RATIO),
        .KEEP_W (PACK_RATIO)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (r_acc),
        .i_keep  (w_load_keep),
        .i_ready (out_ready),
        .o_free  (w_slot_free),
        .o_valid (w_out_valid),
        .o_data  (out_data),
        .o_keep  (out_keep)
    );

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = w_out_valid;
    assign flush_done = r_flush_done;
    assign busy       = (r_fill != '0) || r_rd_pending || w_out_valid || (r_state != RUN);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a FIFO model feeds the DUT, stimulus
// queues hand-computed beats and a monitor thread checks every handshake.
module tb_fifo_rd_packer;

    localparam int FW = 16;
    localparam int PR = 4;
    localparam int DW = FW * PR;

    typedef struct {
        logic [DW-1:0] data;
        logic [PR-1:0] keep;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [FW-1:0] fifo_data_out = '0;
    logic          fifo_rd_en;
    logic [DW-1:0] out_data;
    logic [PR-1:0] out_keep;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          busy;

    logic [FW-1:0] fifo_mem [0:255];
    int            pushed_cnt  = 0;
    int            popped_cnt  = 0;
    int            empty_reads = 0;

    beat_t         exp_q[$];
    beat_t         mon_beat;
    logic          mon_held = 1'b0;
    logic [DW-1:0] mon_data;
    logic [PR-1:0] mon_keep;
    int            n_compared = 0;
    int            n_mismatch = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (pushed_cnt == popped_cnt);

    fifo_rd_packer #(
        .FIFO_WIDTH (FW),
        .PACK_RATIO (PR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .flush         (flush),
        .flush_done    (flush_done),
        .busy          (busy)
    );

    // Synchronous FIFO model: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) begin
                empty_reads <= empty_reads + 1;
            end else begin
                fifo_data_out <= fifo_mem[popped_cnt[7:0]];
                popped_cnt    <= popped_cnt + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [FW-1:0] word);
        fifo_mem[pushed_cnt[7:0]] = word;
        pushed_cnt++;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectBeat(input logic [DW-1:0] d, input logic [PR-1:0] k);
        beat_t b;
        b.data = d;
        b.keep = k;
        exp_q.push_back(b);
    endtask

    task automatic waitIdle(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 200) begin
            tick(1);
            cyc++;
        end
        checkOutput(name, 64'(cyc < 200), 64'd1);
    endtask

    task automatic waitFlushDone(input string name);
        int cyc;
        cyc = 0;
        while (!flush_done && cyc < 10) begin
            tick(1);
            cyc++;
        end
        checkOutput(name, 64'(flush_done), 64'd1);
    endtask

    initial begin
        fork
            begin : stim
                int   base;
                int   rd_hi;
                int   beat_cyc;
                int   done_cyc;
                int   done_cnt;
                logic seen;
                logic any_valid;

                rst       = 1'b1;
                out_ready = 1'b1;
                flush     = 1'b0;
                tick(3);
                checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
                checkOutput("rst_out_data", out_data, 64'd0);
                checkOutput("rst_out_keep", 64'(out_keep), 64'd0);
                checkOutput("rst_flush_done", 64'(flush_done), 64'd0);
                checkOutput("rst_rd_en", 64'(fifo_rd_en), 64'd0);
                checkOutput("rst_busy", 64'(busy), 64'd0);
                rst = 1'b0;
                tick(1);

                $display("[TB] directed read and pack");
                base = popped_cnt;
                for (int i = 1; i <= 8; i++) applyStimulus(FW'(i));
                expectBeat(64'h0004_0003_0002_0001, 4'hF);
                expectBeat(64'h0008_0007_0006_0005, 4'hF);
                waitIdle("t1_idle");
                checkOutput("t1_reads", 64'(popped_cnt - base), 64'd8);
                checkOutput("t1_empty_reads", 64'(empty_reads), 64'd0);

                $display("[TB] backpressure");
                out_ready = 1'b0;
                base      = popped_cnt;
                for (int i = 1; i <= 12; i++) applyStimulus(16'h0100 + FW'(i));
                expectBeat(64'h0104_0103_0102_0101, 4'hF);
                expectBeat(64'h0108_0107_0106_0105, 4'hF);
                expectBeat(64'h010C_010B_010A_0109, 4'hF);
                tick(20);
                checkOutput("t2_held_valid", 64'(out_valid), 64'd1);
                checkOutput("t2_held_data", out_data, 64'h0104_0103_0102_0101);
                rd_hi = 0;
                for (int i = 0; i < 4; i++) begin
                    if (fifo_rd_en) rd_hi++;
                    tick(1);
                end
                checkOutput("t2_no_reads_when_full", 64'(rd_hi), 64'd0);
                checkOutput("t2_reads_stalled", 64'(popped_cnt - base), 64'd8);
                out_ready = 1'b1;
                waitIdle("t2_idle");
                checkOutput("t2_reads", 64'(popped_cnt - base), 64'd12);

                $display("[TB] partial flush");
                base = popped_cnt;
                applyStimulus(16'h00A1);
                applyStimulus(16'h00A2);
                applyStimulus(16'h00A3);
                expectBeat(64'h0000_00A3_00A2_00A1, 4'b0111);
                tick(6);
                checkOutput("t3_reads", 64'(popped_cnt - base), 64'd3);
                flush = 1'b1;
                tick(1);
                flush    = 1'b0;
                beat_cyc = -1;
                done_cyc = -1;
                done_cnt = 0;
                for (int k = 1; k <= 6; k++) begin
                    tick(1);
                    if (out_valid && beat_cyc < 0) beat_cyc = k;
                    if (flush_done) begin
                        done_cnt++;
                        if (done_cyc < 0) done_cyc = k;
                    end
                end
                checkOutput("t3_done_pulses", 64'(done_cnt), 64'd1);
                checkOutput("t3_done_after_load",
                            64'(beat_cyc > 0 && (done_cyc - beat_cyc == 0 || done_cyc - beat_cyc == 1)), 64'd1);
                waitIdle("t3_idle");

                $display("[TB] flush with in-flight read");
                base = popped_cnt;
                applyStimulus(16'h00C1);
                applyStimulus(16'h00C2);
                applyStimulus(16'h00C3);
                expectBeat(64'h0000_0000_00C2_00C1, 4'b0011);
                expectBeat(64'h0000_0000_0000_00C3, 4'b0001);
                tick(1);
                flush = 1'b1;
                tick(1);
                flush = 1'b0;
                waitFlushDone("t4_flush_done");
                checkOutput("t4_reads_during_flush", 64'(popped_cnt - base), 64'd2);
                tick(4);
                flush = 1'b1;
                tick(1);
                flush = 1'b0;
                waitFlushDone("t4_second_flush_done");
                waitIdle("t4_idle");
                checkOutput("t4_reads", 64'(popped_cnt - base), 64'd3);

                $display("[TB] empty flush");
                flush = 1'b1;
                tick(1);
                flush     = 1'b0;
                seen      = 1'b0;
                any_valid = 1'b0;
                for (int k = 1; k <= 2; k++) begin
                    tick(1);
                    if (flush_done) seen = 1'b1;
                    if (out_valid) any_valid = 1'b1;
                end
                checkOutput("t5_done_within_2", 64'(seen), 64'd1);
                for (int k = 1; k <= 3; k++) begin
                    tick(1);
                    if (out_valid) any_valid = 1'b1;
                end
                checkOutput("t5_no_valid", 64'(any_valid), 64'd0);

                $display("[TB] reset mid-beat");
                out_ready = 1'b0;
                base      = popped_cnt;
                for (int i = 1; i <= 6; i++) applyStimulus(16'h00E0 + FW'(i));
                tick(16);
                checkOutput("t6_pre_valid", 64'(out_valid), 64'd1);
                checkOutput("t6_pre_data", out_data, 64'h00E4_00E3_00E2_00E1);
                checkOutput("t6_pre_reads", 64'(popped_cnt - base), 64'd6);
                checkOutput("t6_pre_busy", 64'(busy), 64'd1);
                rst = 1'b1;
                tick(1);
                checkOutput("t6_rst_out_valid", 64'(out_valid), 64'd0);
                checkOutput("t6_rst_out_data", out_data, 64'd0);
                checkOutput("t6_rst_out_keep", 64'(out_keep), 64'd0);
                checkOutput("t6_rst_flush_done", 64'(flush_done), 64'd0);
                checkOutput("t6_rst_rd_en", 64'(fifo_rd_en), 64'd0);
                checkOutput("t6_rst_busy", 64'(busy), 64'd0);
                rst       = 1'b0;
                out_ready = 1'b1;
                for (int i = 1; i <= 4; i++) applyStimulus(16'h00F0 + FW'(i));
                expectBeat(64'h00F4_00F3_00F2_00F1, 4'hF);
                waitIdle("t6_idle");

                checkOutput("end_empty_reads", 64'(empty_reads), 64'd0);
                checkOutput("end_scoreboard_drained", 64'(exp_q.size()), 64'd0);
            end

            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        mon_held = 1'b0;
                    end else begin
                        if (mon_held) begin
                            checkOutput("hold_valid", 64'(out_valid), 64'd1);
                            checkOutput("hold_data", out_data, mon_data);
                            checkOutput("hold_keep", 64'(out_keep), 64'(mon_keep));
                        end
                        if (out_valid && out_ready) begin
                            if (exp_q.size() == 0) begin
                                n_compared++;
                                n_mismatch++;
                                $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
                            end else begin
                                mon_beat = exp_q.pop_front();
                                checkOutput("beat_data", out_data, mon_beat.data);
                                checkOutput("beat_keep", 64'(out_keep), 64'(mon_beat.keep));
                            end
                        end
                        mon_held = out_valid && !out_ready;
                        mon_data = out_data;
                        mon_keep = out_keep;
                    end
                end
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
